mul_div_sequencer: RTL and testbench
====================================

Name: mul_div_sequencer

Overview:
Iterative 32-bit unsigned multiply/divide unit. It time-multiplexes one instance of the existing generic adder over one iteration per clock. It is built for the VCPU-32 execute stage: it accepts an operand pair through a valid/ready handshake, runs a fixed number of shift/add (or shift/subtract) steps, and presents a 2-word result until the consumer takes it.

Parameters:
WIDTH, `WORD_LENGTH (32), operand/result word width; bit 0 is the MSB, matching the [0:WIDTH-1] ordering of the datapath.

Ports:
clk  in  1  single clock; all state changes on rising edge
rst  in  1  synchronous, active-low reset; sampled on rising edge of clk
inValid  in  1  operands and op presented
inReady  out  1  block can accept; high only in IDLE
op  in  1  0 = MUL (unsigned), 1 = DIV (unsigned restoring)
a  in  WIDTH  multiplicand / dividend
b  in  WIDTH  multiplier / divisor
outValid  out  1  result valid; held until accepted
outReady  in  1  consumer accepts result
resHi  out  WIDTH  MUL: product[0:WIDTH-1] (upper word); DIV: remainder
resLo  out  WIDTH  MUL: product[WIDTH:2*WIDTH-1] (lower word); DIV: quotient
divZero  out  1  DIV with b == 0; valid with outValid

Behaviour:
- Reset (rst == 0 at an edge): state IDLE, count 0. inReady = 1, outValid = 0, resHi = resLo = 0, divZero = 0. Reset overrides everything, including mid-RUN and mid-DONE; the in-flight operation is discarded silently.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: inReady = 1.
  - On inValid && inReady: latch op, a, b into registers and clear divZero.
  - MUL: hi = 0, lo = b, mcand = a.
  - DIV: hi = 0, lo = a, dsor = b.
  - Go to RUN with count = 0.
  - DIV with b == 0 goes straight to DONE: resHi = a, resLo = all ones, divZero = 1.
- RUN: exactly WIDTH cycles (count 0..WIDTH-1), one adder use per cycle.
  - MUL step: adder computes hi + mcand with inC = 0. If lo[WIDTH-1] == 1, then {hi,lo} <= {outC, s, lo[0:WIDTH-2]}; otherwise {hi,lo} <= {1'b0, hi, lo[0:WIDTH-2]}.
  - DIV step: t = hi[0], shifted = {hi[1:WIDTH-1], lo[0]}. Adder computes shifted + ~dsor with inC = 1.
    - If t == 1 or outC == 1: hi <= s, lo <= {lo[1:WIDTH-1], 1}.
    - Otherwise: hi <= shifted, lo <= {lo[1:WIDTH-1], 0}.
  - At count == WIDTH-1: go to DONE; count saturates, no wrap.
- DONE: outValid = 1; resHi/resLo/divZero are stable.
  - On outReady, go to IDLE; outValid drops the next cycle.
  - If outReady is low, hold indefinitely.
- inReady is 0 in RUN and DONE. inValid during those states is ignored; the producer must hold it.
- Latency: acceptance edge at cycle N gives outValid first high in cycle N+WIDTH+1 (33 for WIDTH = 32). The divide-by-zero path gives outValid in cycle N+1.
- Back-to-back: the earliest next acceptance is the cycle after the DONE handshake. There is no overlap of IDLE with DONE.
- Operand inputs are sampled only on acceptance; later changes have no effect.
- Adder inputs are muxed only from internal registers, never from ports directly.
- resHi/resLo show internal working registers during RUN. They are valid only when outValid = 1.

Decomposition:
- Shared VCPU32 include: OP_MUL = 1'b0, OP_DIV = 1'b1 constants; state encodings SEQ_IDLE, SEQ_RUN, SEQ_DONE (2-bit).
- Counter width is $clog2(WIDTH).
- One sub-module: a single AdderUnit #(.WIDTH(WIDTH)) instance. There is no second adder; all arithmetic goes through it.

Test Plan:
- MUL a = 10, b = 5, outReady = 1 -> resHi = 0x00000000, resLo = 0x00000032, outValid exactly 33 cycles after acceptance, divZero = 0.
- MUL a = 0xFFFFFFFF, b = 0xFFFFFFFF -> resHi = 0xFFFFFFFE, resLo = 0x00000001; also a = 0xFFFFFFFF, b = 1 -> resHi = 0, resLo = 0xFFFFFFFF.
- DIV a = 100, b = 7 -> resLo = 0x0000000E, resHi = 0x00000002; DIV a = 0xFFFFFFFF, b = 1 -> resLo = 0xFFFFFFFF, resHi = 0.
- DIV a = 0x1234, b = 0 -> outValid in cycle N+1, divZero = 1, resHi = 0x00001234, resLo = 0xFFFFFFFF.
- Backpressure: outReady held low 10 cycles after DONE -> outValid and results stable, inReady = 0, a second inValid is not accepted. Raise outReady -> IDLE next cycle, then the second operation is accepted.
- Reset: rst = 0 at RUN count 15 -> next cycle outValid = 0, inReady = 1, resHi = resLo = 0. A fresh MUL 3*4 then yields resLo = 12.

Source files
------------

// File: rtl/mul_div_sequencer_pkg.sv
// Shared constants for the iterative multiply/divide sequencer.
package mul_div_sequencer_pkg;

  localparam int WORD_LENGTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/mul_div_sequencer_adder.sv
// Generic ripple adder with carry in/out; bit 0 is the MSB.
module AdderUnit #(
  parameter int WIDTH = 32
) (
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  input  logic             inC,
  output logic [0:WIDTH-1] s,
  output logic             outC
);

  // Single combinational add producing carry-out as the extra top bit.
  always_comb begin
    {outC, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, inC};
  end

endmodule

// File: rtl/mul_div_sequencer.sv
// Iterative unsigned multiply / restoring divide, one adder use per cycle.
module mul_div_sequencer
  import mul_div_sequencer_pkg::*;
#(
  parameter int WIDTH = WORD_LENGTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic             op,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  output logic             outValid,
  input  logic             outReady,
  output logic [0:WIDTH-1] resHi,
  output logic [0:WIDTH-1] resLo,
  output logic             divZero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  seq_state_t       state;
  seq_state_t       state_next;
  logic [CNT_W-1:0] count;
  logic             op_r;
  logic [0:WIDTH-1] hi;
  logic [0:WIDTH-1] lo;
  logic [0:WIDTH-1] oper;      // multiplicand for MUL, divisor for DIV
  logic             div_zero;

  logic [0:WIDTH-1] add_a;
  logic [0:WIDTH-1] add_b;
  logic             add_cin;
  logic [0:WIDTH-1] sum_s;
  logic             sum_c;
  logic [0:WIDTH-1] shifted;
  logic             div_top;
  logic             b_is_zero;

  assign shifted   = {hi[1:WIDTH-1], lo[0]};
  assign div_top   = hi[0];
  assign b_is_zero = (b == '0);

  // Adder operand select: only registered values feed the shared adder.
  always_comb begin
    add_a   = hi;
    add_b   = oper;
    add_cin = 1'b0;
    if (op_r == OP_DIV) begin
      add_a   = shifted;
      add_b   = ~oper;
      add_cin = 1'b1;
    end
  end

  AdderUnit #(.WIDTH(WIDTH)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .inC  (add_cin),
    .s    (sum_s),
    .outC (sum_c)
  );

  // Next-state logic; divide by zero skips the iteration phase.
  always_comb begin
    state_next = state;
    case (state)
      SEQ_IDLE: if (inValid) state_next = (op == OP_DIV && b_is_zero) ? SEQ_DONE : SEQ_RUN;
      SEQ_RUN:  if (count == LAST) state_next = SEQ_DONE;
      SEQ_DONE: if (outReady) state_next = SEQ_IDLE;
      default:  state_next = SEQ_IDLE;
    endcase
  end

  // State register, operand capture and one shift/add or shift/subtract step per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= SEQ_IDLE;
      count    <= '0;
      op_r     <= OP_MUL;
      hi       <= '0;
      lo       <= '0;
      oper     <= '0;
      div_zero <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        SEQ_IDLE: begin
          if (inValid) begin
            op_r     <= op;
            count    <= '0;
            hi       <= '0;
            div_zero <= 1'b0;
            if (op == OP_MUL) begin
              lo   <= b;
              oper <= a;
            end else begin
              lo   <= a;
              oper <= b;
              if (b_is_zero) begin
                hi       <= a;
                lo       <= '1;
                div_zero <= 1'b1;
              end
            end
          end
        end
        SEQ_RUN: begin
          if (op_r == OP_MUL) begin
            if (lo[WIDTH-1]) {hi, lo} <= {sum_c, sum_s, lo[0:WIDTH-2]};
            else             {hi, lo} <= {1'b0, hi, lo[0:WIDTH-2]};
          end else begin
            if (div_top || sum_c) begin
              hi <= sum_s;
              lo <= {lo[1:WIDTH-1], 1'b1};
            end else begin
              hi <= shifted;
              lo <= {lo[1:WIDTH-1], 1'b0};
            end
          end
          if (count != LAST) count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign inReady  = (state == SEQ_IDLE);
  assign outValid = (state == SEQ_DONE);
  assign resHi    = hi;
  assign resLo    = lo;
  assign divZero  = div_zero;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Randomized and directed checks of the multiply/divide sequencer against an arithmetic model.
module tb_mul_div_sequencer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          inValid = 1'b0;
  logic          inReady;
  logic          op = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          outValid;
  logic          outReady = 1'b0;
  logic [W-1:0]  resHi;
  logic [W-1:0]  resLo;
  logic          divZero;

  int total = 0;
  int bad   = 0;

  mul_div_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .inValid  (inValid),
    .inReady  (inReady),
    .op       (op),
    .a        (a),
    .b        (b),
    .outValid (outValid),
    .outReady (outReady),
    .resHi    (resHi),
    .resLo    (resLo),
    .divZero  (divZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected results straight from integer arithmetic.
  task automatic model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    logic [63:0] p;
    dz = 1'b0;
    if (o == 1'b0) begin
      p  = 64'(x) * 64'(y);
      hi = p[63:32];
      lo = p[31:0];
    end else if (y == 0) begin
      hi = x;
      lo = '1;
      dz = 1'b1;
    end else begin
      hi = x % y;
      lo = x / y;
    end
  endtask

  // Present operands, count cycles from acceptance to outValid, leave DONE held.
  task automatic start_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, output int cyc);
    op = o; a = x; b = y; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    a = $urandom; b = $urandom; op = $urandom_range(0, 1);
    cyc = 1;
    while (!outValid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit chk_lat);
    int cyc;
    logic [W-1:0] eh, el;
    logic edz;
    model(o, x, y, eh, el, edz);
    start_op(o, x, y, cyc);
    if (chk_lat) chk({tag, "_lat"}, 64'(cyc), edz ? 64'd1 : 64'(W + 1));
    chk({tag, "_hi"}, 64'(resHi), 64'(eh));
    chk({tag, "_lo"}, 64'(resLo), 64'(el));
    chk({tag, "_dz"}, 64'(divZero), 64'(edz));
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    chk({tag, "_idle"}, {62'd0, outValid, inReady}, 64'd1);
  endtask

  initial begin
    int cyc;
    logic [W-1:0] eh, el, h0, l0;
    logic edz;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {60'd0, outValid, inReady, divZero, 1'b0}, 64'd4);
    chk("rst_res", {resHi, resLo}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op("mul_10x5", 1'b0, 32'd10, 32'd5, 1'b1);
    run_op("mul_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    run_op("mul_max1", 1'b0, 32'hFFFFFFFF, 32'd1, 1'b0);
    run_op("div_100_7", 1'b1, 32'd100, 32'd7, 1'b1);
    run_op("div_max1", 1'b1, 32'hFFFFFFFF, 32'd1, 1'b0);
    run_op("div_zero", 1'b1, 32'h1234, 32'd0, 1'b1);
    run_op("div_small", 1'b1, 32'd3, 32'd9, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] x, y;
      logic o;
      o = $urandom_range(0, 1);
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'($urandom_range(0, 15));
        1: y = x >> $urandom_range(0, 31);
        default: y = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), o, x, y, 1'b0);
    end

    // Backpressure: result must hold and a second request must wait.
    model(1'b0, 32'h1357, 32'h2468, eh, el, edz);
    start_op(1'b0, 32'h1357, 32'h2468, cyc);
    chk("bp_lat", 64'(cyc), 64'(W + 1));
    op = 1'b1; a = 32'd1000; b = 32'd33; inValid = 1'b1;
    h0 = resHi; l0 = resLo;
    chk("bp_res", {h0, l0}, {eh, el});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {61'd0, outValid, inReady, divZero}, 64'd4);
      chk("bp_stable", {resHi, resLo}, {eh, el});
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    chk("bp_release", {62'd0, outValid, inReady}, 64'd1);
    @(posedge clk); #1;
    inValid = 1'b0;
    chk("bp_second_acc", 64'(inReady), 64'd0);
    cyc = 1;
    while (!outValid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    model(1'b1, 32'd1000, 32'd33, eh, el, edz);
    chk("bp_second_lat", 64'(cyc), 64'(W + 1));
    chk("bp_second_res", {resHi, resLo}, {eh, el});
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;

    // Reset in the middle of an iteration.
    op = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("mid_busy", {62'd0, outValid, inReady}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("mid_rst_ctl", {62'd0, outValid, inReady}, 64'd1);
    chk("mid_rst_res", {resHi, resLo}, 64'd0);
    run_op("mul_3x4", 1'b0, 32'd3, 32'd4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
